// File: rtl/udp_rx_parser.sv
// Byte-serial UDP receive parser: captures the header, filters on a destination-port
// window, and emits payload bounded by the UDP length field with error flagging.
module udp_rx_parser #(
  parameter logic [15:0] PORT_BASE = 16'd5000,
  parameter int          NUM_PORTS = 4,
  parameter bit          FILTER_EN = 1'b1,
  parameter int          IDX_W     = 8
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic [7:0]       datain,
  input  logic             data_en,
  output logic [15:0]      pc_port,
  output logic [15:0]      board_port,
  output logic [15:0]      udp_len,
  output logic [15:0]      udp_csum,
  output logic [IDX_W-1:0] port_idx,
  output logic             hdr_valid,
  output logic             payload_en,
  output logic [7:0]       payload_data,
  output logic             payload_sop,
  output logic             payload_eop,
  output logic             len_err,
  output logic             trunc_err,
  output logic             drop
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    PAD     = 3'd3,
    DROP    = 3'd4
  } state_t;

  // 17-bit window bounds so PORT_BASE+NUM_PORTS never wraps past 16'hFFFF.
  localparam logic [16:0] WIN_LO = {1'b0, PORT_BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(NUM_PORTS) - 17'd1;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [15:0]      pc_port_q, pc_port_d;
  logic [15:0]      board_port_q, board_port_d;
  logic [15:0]      udp_len_q, udp_len_d;
  logic [15:0]      udp_csum_q, udp_csum_d;
  logic [IDX_W-1:0] port_idx_q, port_idx_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             payload_en_q, payload_en_d;
  logic [7:0]       payload_data_q, payload_data_d;
  logic             payload_sop_q, payload_sop_d;
  logic             payload_eop_q, payload_eop_d;
  logic             len_err_q, len_err_d;
  logic             trunc_err_q, trunc_err_d;
  logic             drop_q, drop_d;

  logic             in_window;
  logic             len_short;
  logic [15:0]      len_last;

  assign in_window = ({1'b0, board_port_q} >= WIN_LO) && ({1'b0, board_port_q} <= WIN_HI);
  assign len_short = udp_len_q < 16'd8;
  assign len_last  = udp_len_q - 16'd1;

  // State register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!data_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) state_d = HDR;
        end
        HDR: begin
          if (cnt_q == 16'd7) begin
            if (len_short)                    state_d = DROP;
            else if (FILTER_EN && !in_window) state_d = DROP;
            else if (udp_len_q == 16'd8)      state_d = PAD;
            else                              state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (cnt_q == len_last) state_d = PAD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath logic
  always_comb begin
    cnt_d          = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // After an asynchronous reset, wait for a gap before accepting a new datagram.
    armed_d        = armed_q | ~data_en;
    pc_port_d      = pc_port_q;
    board_port_d   = board_port_q;
    udp_len_d      = udp_len_q;
    udp_csum_d     = udp_csum_q;
    port_idx_d     = port_idx_q;
    payload_data_d = payload_data_q;
    hdr_valid_d    = 1'b0;
    payload_en_d   = 1'b0;
    payload_sop_d  = 1'b0;
    payload_eop_d  = 1'b0;
    len_err_d      = 1'b0;
    trunc_err_d    = 1'b0;
    drop_d         = 1'b0;

    if (!data_en) begin
      cnt_d       = 16'd0;
      trunc_err_d = (state_q == HDR) || (state_q == PAYLOAD);
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) pc_port_d[15:8] = datain;
        end
        HDR: begin
          case (cnt_q)
            16'd1: pc_port_d[7:0]     = datain;
            16'd2: board_port_d[15:8] = datain;
            16'd3: board_port_d[7:0]  = datain;
            16'd4: udp_len_d[15:8]    = datain;
            16'd5: udp_len_d[7:0]     = datain;
            16'd6: udp_csum_d[15:8]   = datain;
            16'd7: begin
              udp_csum_d[7:0] = datain;
              if (len_short) begin
                len_err_d = 1'b1;
              end else if (FILTER_EN && !in_window) begin
                drop_d = 1'b1;
              end else begin
                hdr_valid_d = 1'b1;
                port_idx_d  = IDX_W'(board_port_q - PORT_BASE);
              end
            end
            default: ;
          endcase
        end
        PAYLOAD: begin
          payload_en_d   = 1'b1;
          payload_data_d = datain;
          payload_sop_d  = (cnt_q == 16'd8);
          payload_eop_d  = (cnt_q == len_last);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q          <= 16'd0;
      armed_q        <= 1'b0;
      pc_port_q      <= 16'd0;
      board_port_q   <= 16'd0;
      udp_len_q      <= 16'd0;
      udp_csum_q     <= 16'd0;
      port_idx_q     <= '0;
      hdr_valid_q    <= 1'b0;
      payload_en_q   <= 1'b0;
      payload_data_q <= 8'd0;
      payload_sop_q  <= 1'b0;
      payload_eop_q  <= 1'b0;
      len_err_q      <= 1'b0;
      trunc_err_q    <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      pc_port_q      <= pc_port_d;
      board_port_q   <= board_port_d;
      udp_len_q      <= udp_len_d;
      udp_csum_q     <= udp_csum_d;
      port_idx_q     <= port_idx_d;
      hdr_valid_q    <= hdr_valid_d;
      payload_en_q   <= payload_en_d;
      payload_data_q <= payload_data_d;
      payload_sop_q  <= payload_sop_d;
      payload_eop_q  <= payload_eop_d;
      len_err_q      <= len_err_d;
      trunc_err_q    <= trunc_err_d;
      drop_q         <= drop_d;
    end
  end

  assign pc_port      = pc_port_q;
  assign board_port   = board_port_q;
  assign udp_len      = udp_len_q;
  assign udp_csum     = udp_csum_q;
  assign port_idx     = port_idx_q;
  assign hdr_valid    = hdr_valid_q;
  assign payload_en   = payload_en_q;
  assign payload_data = payload_data_q;
  assign payload_sop  = payload_sop_q;
  assign payload_eop  = payload_eop_q;
  assign len_err      = len_err_q;
  assign trunc_err    = trunc_err_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: one filtering instance and one accept-all
// instance share the same byte stream.
module tb_udp_rx_parser;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic [7:0]  datain = 8'd0;
  logic        data_en = 1'b0;

  logic [15:0] pc_port, board_port, udp_len, udp_csum;
  logic [7:0]  port_idx, payload_data;
  logic        hdr_valid, payload_en, payload_sop, payload_eop, len_err, trunc_err, drop;

  logic [15:0] pc_port_n, board_port_n, udp_len_n, udp_csum_n;
  logic [7:0]  port_idx_n, payload_data_n;
  logic        hdr_valid_n, payload_en_n, payload_sop_n, payload_eop_n, len_err_n, trunc_err_n, drop_n;

  always #5 clock = ~clock;

  udp_rx_parser #(.PORT_BASE(16'd5000), .NUM_PORTS(4), .FILTER_EN(1'b1), .IDX_W(8)) dut (
    .clock(clock), .aclr_n(aclr_n), .datain(datain), .data_en(data_en),
    .pc_port(pc_port), .board_port(board_port), .udp_len(udp_len), .udp_csum(udp_csum),
    .port_idx(port_idx), .hdr_valid(hdr_valid), .payload_en(payload_en),
    .payload_data(payload_data), .payload_sop(payload_sop), .payload_eop(payload_eop),
    .len_err(len_err), .trunc_err(trunc_err), .drop(drop)
  );

  udp_rx_parser #(.PORT_BASE(16'd5000), .NUM_PORTS(4), .FILTER_EN(1'b0), .IDX_W(8)) dut_nf (
    .clock(clock), .aclr_n(aclr_n), .datain(datain), .data_en(data_en),
    .pc_port(pc_port_n), .board_port(board_port_n), .udp_len(udp_len_n), .udp_csum(udp_csum_n),
    .port_idx(port_idx_n), .hdr_valid(hdr_valid_n), .payload_en(payload_en_n),
    .payload_data(payload_data_n), .payload_sop(payload_sop_n), .payload_eop(payload_eop_n),
    .len_err(len_err_n), .trunc_err(trunc_err_n), .drop(drop_n)
  );

  // Event log filled on the falling edge, away from the sampling edge.
  int          hv_cnt = 0, le_cnt = 0, dr_cnt = 0, te_cnt = 0;
  logic [7:0]  pl_q[$];
  int          sop_q[$];
  int          eop_q[$];
  logic [7:0]  idx_q[$];
  logic [15:0] src_q[$];
  int          hvn_cnt = 0, pln_cnt = 0, sopn_cnt = 0, eopn_cnt = 0, errn_cnt = 0;
  logic [7:0]  idxn_last = 8'd0;
  logic [7:0]  datn_last = 8'd0;

  always @(negedge clock) begin
    if (hdr_valid) begin
      hv_cnt++;
      idx_q.push_back(port_idx);
      src_q.push_back(pc_port);
    end
    if (len_err)   le_cnt++;
    if (drop)      dr_cnt++;
    if (trunc_err) te_cnt++;
    if (payload_en) begin
      if (payload_sop) sop_q.push_back(pl_q.size());
      if (payload_eop) eop_q.push_back(pl_q.size());
      pl_q.push_back(payload_data);
    end
    if (hdr_valid_n) begin
      hvn_cnt++;
      idxn_last = port_idx_n;
    end
    if (payload_en_n) begin
      pln_cnt++;
      datn_last = payload_data_n;
    end
    if (payload_sop_n) sopn_cnt++;
    if (payload_eop_n) eopn_cnt++;
    if (len_err_n || trunc_err_n || drop_n) errn_cnt++;
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fr[$];
  logic [7:0] pay[$];

  task automatic mk(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                    input int npad);
    fr.delete();
    fr.push_back(src[15:8]); fr.push_back(src[7:0]);
    fr.push_back(dst[15:8]); fr.push_back(dst[7:0]);
    fr.push_back(len[15:8]); fr.push_back(len[7:0]);
    fr.push_back(8'hAB);     fr.push_back(8'hCD);
    foreach (pay[k]) fr.push_back(pay[k]);
    for (int k = 0; k < npad; k++) fr.push_back(8'h55);
  endtask

  task automatic send(input int n, input int gap, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      aclr_n  = 1'b1;
      datain  = fr[i];
      data_en = 1'b1;
      if (i == rst_at) begin
        #2 aclr_n = 1'b0;
        #1;
        chk("rst_pc_port", 32'(pc_port), 32'h0);
        chk("rst_board_port", 32'(board_port), 32'h0);
        chk("rst_udp_len", 32'(udp_len), 32'h0);
        chk("rst_payload_en", 32'(payload_en), 32'h0);
        chk("rst_payload_data", 32'(payload_data), 32'h0);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      aclr_n  = 1'b1;
      data_en = 1'b0;
      datain  = 8'd0;
    end
    #1;
  endtask

  int b_hv, b_le, b_dr, b_te, b_pl, b_eop, b_hvn, b_pln, b_sopn, b_eopn, b_errn;

  task automatic mark();
    b_hv = hv_cnt; b_le = le_cnt; b_dr = dr_cnt; b_te = te_cnt;
    b_pl = pl_q.size(); b_eop = eop_q.size();
    b_hvn = hvn_cnt; b_pln = pln_cnt; b_sopn = sopn_cnt; b_eopn = eopn_cnt; b_errn = errn_cnt;
  endtask

  task automatic nominal(input string tg);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mk(16'h1234, 16'h1389, 16'd12, 6);
    mark();
    send(18, 3, -1);
    chk({tg, "_pc_port"}, 32'(pc_port), 32'h1234);
    chk({tg, "_board_port"}, 32'(board_port), 32'h1389);
    chk({tg, "_udp_len"}, 32'(udp_len), 32'h000C);
    chk({tg, "_udp_csum"}, 32'(udp_csum), 32'hABCD);
    chk({tg, "_hv_cnt"}, 32'(hv_cnt - b_hv), 32'd1);
    chk({tg, "_port_idx"}, 32'(idx_q[$]), 32'h01);
    chk({tg, "_pl_cnt"}, 32'(pl_q.size() - b_pl), 32'd4);
    chk({tg, "_pl0"}, 32'(pl_q[b_pl + 0]), 32'hDE);
    chk({tg, "_pl1"}, 32'(pl_q[b_pl + 1]), 32'hAD);
    chk({tg, "_pl2"}, 32'(pl_q[b_pl + 2]), 32'hBE);
    chk({tg, "_pl3"}, 32'(pl_q[b_pl + 3]), 32'hEF);
    chk({tg, "_sop_pos"}, 32'(sop_q[$]), 32'(b_pl));
    chk({tg, "_eop_cnt"}, 32'(eop_q.size() - b_eop), 32'd1);
    chk({tg, "_eop_pos"}, 32'(eop_q[$]), 32'(b_pl + 3));
    chk({tg, "_te_cnt"}, 32'(te_cnt - b_te), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_pc_port", 32'(pc_port), 32'h0);
    chk("reset_board_port", 32'(board_port), 32'h0);
    chk("reset_udp_len", 32'(udp_len), 32'h0);
    chk("reset_udp_csum", 32'(udp_csum), 32'h0);
    chk("reset_port_idx", 32'(port_idx), 32'h0);
    chk("reset_hdr_valid", 32'(hdr_valid), 32'h0);
    chk("reset_payload_en", 32'(payload_en), 32'h0);
    aclr_n = 1'b1;
    repeat (2) @(negedge clock);

    nominal("nom");

    // Filter reject on dut, accept with truncated index on dut_nf
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mk(16'h1234, 16'h1390, 16'd12, 6);
    mark();
    send(18, 3, -1);
    chk("flt_drop_cnt", 32'(dr_cnt - b_dr), 32'd1);
    chk("flt_hv_cnt", 32'(hv_cnt - b_hv), 32'd0);
    chk("flt_pl_cnt", 32'(pl_q.size() - b_pl), 32'd0);
    chk("flt_board_port", 32'(board_port), 32'h1390);
    chk("nf_hv_cnt", 32'(hvn_cnt - b_hvn), 32'd1);
    chk("nf_port_idx", 32'(idxn_last), 32'h08);
    chk("nf_pl_cnt", 32'(pln_cnt - b_pln), 32'd4);
    chk("nf_last_byte", 32'(datn_last), 32'hEF);
    chk("nf_sop_cnt", 32'(sopn_cnt - b_sopn), 32'd1);
    chk("nf_eop_cnt", 32'(eopn_cnt - b_eopn), 32'd1);
    chk("nf_err_cnt", 32'(errn_cnt - b_errn), 32'd0);
    chk("nf_fields", {udp_len_n, udp_csum_n}, 32'h000CABCD);
    chk("nf_ports", {pc_port_n, board_port_n}, 32'h12341390);

    // len = 8: header only
    pay.delete();
    mk(16'h1234, 16'h1389, 16'd8, 4);
    mark();
    send(12, 3, -1);
    chk("len8_hv_cnt", 32'(hv_cnt - b_hv), 32'd1);
    chk("len8_pl_cnt", 32'(pl_q.size() - b_pl), 32'd0);
    chk("len8_le_cnt", 32'(le_cnt - b_le), 32'd0);
    chk("len8_udp_len", 32'(udp_len), 32'h0008);

    // len = 7: malformed
    mk(16'h1234, 16'h1389, 16'd7, 4);
    mark();
    send(12, 3, -1);
    chk("len7_le_cnt", 32'(le_cnt - b_le), 32'd1);
    chk("len7_hv_cnt", 32'(hv_cnt - b_hv), 32'd0);
    chk("len7_pl_cnt", 32'(pl_q.size() - b_pl), 32'd0);
    chk("len7_dr_cnt", 32'(dr_cnt - b_dr), 32'd0);

    // len = 9: single payload byte, sop and eop together
    pay = '{8'h5A};
    mk(16'h1234, 16'h1389, 16'd9, 3);
    mark();
    send(12, 3, -1);
    chk("len9_hv_cnt", 32'(hv_cnt - b_hv), 32'd1);
    chk("len9_pl_cnt", 32'(pl_q.size() - b_pl), 32'd1);
    chk("len9_byte", 32'(pl_q[b_pl]), 32'h5A);
    chk("len9_sop_pos", 32'(sop_q[$]), 32'(b_pl));
    chk("len9_eop_pos", 32'(eop_q[$]), 32'(b_pl));

    // Truncation: len 100, only 20 bytes delivered
    pay.delete();
    for (int k = 0; k < 92; k++) pay.push_back(8'(k));
    mk(16'h1234, 16'h1389, 16'd100, 0);
    mark();
    send(20, 3, -1);
    chk("trunc_hv_cnt", 32'(hv_cnt - b_hv), 32'd1);
    chk("trunc_pl_cnt", 32'(pl_q.size() - b_pl), 32'd12);
    chk("trunc_last_byte", 32'(pl_q[$]), 32'h0B);
    chk("trunc_te_cnt", 32'(te_cnt - b_te), 32'd1);
    chk("trunc_eop_cnt", 32'(eop_q.size() - b_eop), 32'd0);
    nominal("after_trunc");

    // Reset asserted for one cycle while byte 10 is on the bus
    pay.delete();
    for (int k = 0; k < 12; k++) pay.push_back(8'(8'h10 + k));
    mk(16'h4321, 16'h138A, 16'd20, 0);
    mark();
    send(20, 3, 10);
    chk("rmid_hv_cnt", 32'(hv_cnt - b_hv), 32'd1);
    chk("rmid_pl_cnt", 32'(pl_q.size() - b_pl), 32'd2);
    chk("rmid_te_cnt", 32'(te_cnt - b_te), 32'd0);
    chk("rmid_eop_cnt", 32'(eop_q.size() - b_eop), 32'd0);
    chk("rmid_pc_port", 32'(pc_port), 32'h0);
    nominal("after_rst");

    // Back-to-back with a single idle cycle
    mark();
    pay = '{8'h01, 8'h02};
    mk(16'h1111, 16'h1388, 16'd10, 0);
    send(10, 1, -1);
    pay = '{8'h0A, 8'h0B, 8'h0C};
    mk(16'h2222, 16'h138B, 16'd11, 2);
    send(13, 3, -1);
    chk("b2b_hv_cnt", 32'(hv_cnt - b_hv), 32'd2);
    chk("b2b_src0", 32'(src_q[b_hv]), 32'h1111);
    chk("b2b_src1", 32'(src_q[b_hv + 1]), 32'h2222);
    chk("b2b_idx0", 32'(idx_q[b_hv]), 32'h00);
    chk("b2b_idx1", 32'(idx_q[b_hv + 1]), 32'h03);
    chk("b2b_pl_cnt", 32'(pl_q.size() - b_pl), 32'd5);
    chk("b2b_pl1", 32'(pl_q[b_pl + 1]), 32'h02);
    chk("b2b_pl2", 32'(pl_q[b_pl + 2]), 32'h0A);
    chk("b2b_pl4", 32'(pl_q[b_pl + 4]), 32'h0C);
    chk("b2b_eop_cnt", 32'(eop_q.size() - b_eop), 32'd2);
    chk("b2b_udp_len", 32'(udp_len), 32'h000B);
    chk("b2b_te_cnt", 32'(te_cnt - b_te), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
